// File: rtl/mm_feed_sequencer.sv
// Sequences one matrix-multiply pass: clear accumulators, K operand reads with
// per-row skewed valids, drain the wavefront, then pulse done. Stall freezes the schedule.
module mm_feed_sequencer #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int CNT_W  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              clear_acc,
  output logic              rd_en,
  output logic [ADDR_W-1:0] k_addr,
  output logic [N-1:0]      row_en,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N - 2);

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic             rd_q;
  logic [N-1:0]     skew;
  logic             adv;

  // Only FEED and DRAIN consume schedule slots; a stalled slot is replayed.
  assign adv = ((state == FEED) || (state == DRAIN)) && !stall;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE:  if (start) nstate = CLEAR;
      CLEAR: begin
        nstate = FEED;
        ncnt   = '0;
      end
      FEED: if (adv) begin
        if (cnt == FEED_LAST) begin
          nstate = DRAIN;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CNT_W'(1);
        end
      end
      DRAIN: if (adv) begin
        if (cnt == DRAIN_LAST) begin
          nstate = DONE;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CNT_W'(1);
        end
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= 1'b0;
      k_addr    <= '0;
      skew      <= '0;
      busy      <= 1'b0;
      clear_acc <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      rd_q      <= (nstate == FEED);
      k_addr    <= (nstate == FEED) ? ncnt[ADDR_W-1:0] : '0;
      busy      <= (nstate != IDLE);
      clear_acc <= (nstate == CLEAR);
      done      <= (nstate == DONE);
      if (adv) skew <= {skew[N-2:0], rd_q};
    end
  end

  // A stalled cycle presents no valid operands; the held registers resume next cycle.
  assign rd_en  = rd_q & ~stall;
  assign row_en = skew & {N{~stall}};

endmodule

// File: tb/tb_mm_feed_sequencer.sv
// Bench for mm_feed_sequencer: directed table, hand sequences and random stimulus
// against a slot-position model, on an N=4/K=4 and an N=2/K=1 instance.
module tb_mm_feed_sequencer;

  typedef struct packed {
    logic       busy;
    logic       clear_acc;
    logic       rd_en;
    logic [2:0] k_addr;
    logic [3:0] row_en;
    logic       done;
  } obs_t;

  typedef struct {
    bit   start;
    bit   stall;
    obs_t exp;
    bit   kchk;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, stall;

  logic       busy_a, clear_a, rd_a, done_a;
  logic [2:0] k_a;
  logic [3:0] row_a;
  logic       busy_b, clear_b, rd_b, done_b;
  logic [0:0] k_b;
  logic [1:0] row_b;

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   pos_a = -1, pos_b = -1;
  obs_t oa, ob;
  int   a_nclr, a_clr_cyc, a_ndone, a_done_cyc;
  int   b_ndone, b_done_cyc, b_nrd, b_rd_cyc;
  int   a_kseq[$];
  vec_t tbl[15];

  always #5 clk = ~clk;

  mm_feed_sequencer #(.N(4), .K(4), .CNT_W(4), .ADDR_W(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy_a), .clear_acc(clear_a), .rd_en(rd_a), .k_addr(k_a),
    .row_en(row_a), .done(done_a));

  mm_feed_sequencer #(.N(2), .K(1), .CNT_W(2), .ADDR_W(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy_b), .clear_acc(clear_b), .rd_en(rd_b), .k_addr(k_b),
    .row_en(row_b), .done(done_b));

  // A pass is a list of slots: 0 = clear, 1..k = reads, k+1..k+2n-1 = drain, k+2n = done.
  // pos is the slot presented this cycle (-1 = idle).
  function automatic obs_t mexp(int n, int k, int pos, bit stl);
    obs_t o = '0;
    if (pos >= 0) begin
      o.busy      = 1'b1;
      o.clear_acc = (pos == 0);
      o.done      = (pos == k + 2 * n);
      o.rd_en     = (pos >= 1) && (pos <= k) && !stl;
      if ((pos >= 1) && (pos <= k)) o.k_addr = 3'(pos - 1);
      for (int i = 0; i < n; i++)
        o.row_en[i] = !stl && (pos >= i + 2) && (pos <= i + k + 1);
    end
    return o;
  endfunction

  function automatic bit infeed(int k, int pos);
    return (pos >= 1) && (pos <= k);
  endfunction

  function automatic int mnext(int n, int k, int pos, bit st, bit sl, bit rs);
    if (rs) return -1;
    if (pos < 0) return st ? 0 : -1;
    if (pos == k + 2 * n) return -1;
    if (pos == 0) return 1;
    return sl ? pos : pos + 1;
  endfunction

  function automatic vec_t mk(bit st, bit sl, bit b, bit c, bit r, int k,
                              logic [3:0] row, bit d, bit kc);
    vec_t v;
    v.start = st;
    v.stall = sl;
    v.exp   = '{busy: b, clear_acc: c, rd_en: r, k_addr: 3'(k), row_en: row, done: d};
    v.kchk  = kc;
    return v;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp, input bit kchk);
    obs_t a = act;
    obs_t e = exp;
    if (!kchk) begin
      a.k_addr = '0;
      e.k_addr = '0;
    end
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b want=%b (busy,clr,rd,k,row,done)", name, cyc, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit sl, input bit rs);
    start = st;
    stall = sl;
    reset = rs;
    @(negedge clk);
    oa = {busy_a, clear_a, rd_a, k_a, row_a, done_a};
    ob = {busy_b, clear_b, rd_b, 2'b00, k_b, 2'b00, row_b, done_b};
    chk("model_a", oa, mexp(4, 4, pos_a, sl), infeed(4, pos_a));
    chk("model_b", ob, mexp(2, 1, pos_b, sl), infeed(1, pos_b));
    if (clear_a) begin a_nclr++; a_clr_cyc = cyc; end
    if (done_a)  begin a_ndone++; a_done_cyc = cyc; end
    if (rd_a)    a_kseq.push_back(int'(k_a));
    if (done_b)  begin b_ndone++; b_done_cyc = cyc; end
    if (rd_b)    begin b_nrd++; b_rd_cyc = cyc; end
  endtask

  task automatic tick();
    @(posedge clk);
    pos_a = mnext(4, 4, pos_a, start, stall, reset);
    pos_b = mnext(2, 1, pos_b, start, stall, reset);
    #1;
    cyc++;
  endtask

  task automatic step(input bit st, input bit sl, input bit rs);
    drive(st, sl, rs);
    tick();
  endtask

  task automatic new_seq();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    cyc = 0;
    a_nclr = 0; a_clr_cyc = -1; a_ndone = 0; a_done_cyc = -1;
    b_ndone = 0; b_done_cyc = -1; b_nrd = 0; b_rd_cyc = -1;
    a_kseq.delete();
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 4'b0000, 0, 1);
    tbl[3]  = mk(0, 0, 1, 0, 1, 1, 4'b0001, 0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 1, 2, 4'b0011, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 1, 3, 4'b0111, 0, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 4'b1111, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 4'b1110, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 4'b1100, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 4'b1000, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 4'b0000, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);

    start = 1'b0; stall = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pos_a = -1; pos_b = -1;

    // reset state, held under start/stall
    drive(1'b1, 1'b1, 1'b1);
    chk("reset_state", oa, '0, 1'b1);
    tick();
    new_seq();

    // basic pass, table-driven
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].stall, 1'b0);
      chk("table", oa, tbl[i].exp, tbl[i].kchk);
      tick();
    end
    chk_int("b_done_cyc", b_done_cyc, 6);
    chk_int("b_rd_count", b_nrd, 1);
    chk_int("b_rd_cyc", b_rd_cyc, 2);
    chk_int("b_done_count", b_ndone, 1);

    // start held high for two back-to-back passes
    new_seq();
    for (int c = 0; c < 28; c++) step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b0);
    chk_int("held_clear_count", a_nclr, 2);
    chk_int("held_clear2_cyc", a_clr_cyc, 15);
    chk_int("held_done_count", a_ndone, 2);
    chk_int("held_done2_cyc", a_done_cyc, 27);

    // stall inside FEED
    new_seq();
    for (int c = 0; c < 17; c++) step(c == 0, (c == 3) || (c == 4), 1'b0);
    chk_int("stall_done_cyc", a_done_cyc, 15);
    chk_int("stall_k_count", a_kseq.size(), 4);
    for (int i = 0; i < a_kseq.size(); i++) chk_int("stall_k_seq", a_kseq[i], i);

    // reset mid-FEED aborts, new start afterwards
    new_seq();
    for (int c = 0; c < 10; c++) begin
      drive((c == 0) || (c == 6), 1'b0, c == 4);
      if (c == 5) chk("abort_idle", oa, '0, 1'b1);
      tick();
    end
    chk_int("abort_done_count", a_ndone, 0);
    chk_int("abort_clear_count", a_nclr, 2);
    chk_int("abort_clear2_cyc", a_clr_cyc, 7);
    for (int c = 0; c < 16; c++) step(1'b0, 1'b0, 1'b0);

    // stall in CLEAR and DONE has no effect
    new_seq();
    for (int c = 0; c < 16; c++) step(c == 0, (c == 1) || (c == 13), 1'b0);
    chk_int("cd_clear_count", a_nclr, 1);
    chk_int("cd_clear_cyc", a_clr_cyc, 1);
    chk_int("cd_done_count", a_ndone, 1);
    chk_int("cd_done_cyc", a_done_cyc, 13);

    // random start/stall/reset against the model
    new_seq();
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
